// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to transmitter and receiver),
// the 16x oversample constant, and default frame geometry.
package uart_pkg;

  localparam int unsigned OVERSAMPLE      = 16;
  localparam int unsigned DBIT_DEFAULT    = 32;
  localparam int unsigned SB_TICK_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = DBIT_DEFAULT,
  parameter int unsigned SB_TICK = SB_TICK_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] tx_din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int unsigned TW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

  uart_state_e     state_q;
  logic [TW-1:0]   tick_q;
  logic [BW-1:0]   bit_q;
  logic [DBIT-1:0] shreg_q;
  logic [DBIT-1:0] shreg_nxt;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;
`ifdef UART_TX_PARITY_EN
  logic            parity_q;
`endif

  assign shreg_nxt    = shreg_q >> 1;
  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          // The done cycle is itself an IDLE cycle; a request seen there waits one more cycle.
          if (tx_start && !done_q) begin
            shreg_q  <= tx_din;
            tick_q   <= '0;
            bit_q    <= '0;
            state_q  <= START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^tx_din;
`endif
          end
        end
        START: begin
          if (s_tick) begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              state_q <= DATA;
              tx_q    <= shreg_q[0];
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              shreg_q <= shreg_nxt;
              if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                state_q <= PARITY;
                tx_q    <= parity_q;
`else
                state_q <= STOP;
                tx_q    <= 1'b1;
`endif
              end else begin
                bit_q <= bit_q + 1'b1;
                tx_q  <= shreg_nxt[0];
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (tick_q == STOP_LAST) begin
              tick_q  <= '0;
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tick_q  <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames, scoreboard of expected payloads,
// and hand sequences for back-to-back, ignored mid-frame requests and mid-frame reset.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int unsigned DBIT    = 32;
  localparam int unsigned SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned FRAME_T = 16 * (1 + DBIT + PBITS) + SB_TICK;
  localparam int unsigned NSMP    = 1024;

  typedef struct {
    logic [DBIT-1:0] din;
    logic            par;
  } vec_t;

  logic            clk      = 1'b0;
  logic            reset_n  = 1'b0;
  logic            tx_start = 1'b0;
  logic            s_tick   = 1'b0;
  logic [DBIT-1:0] tx_din   = '0;
  logic            tx;
  logic            tx_busy;
  logic            tx_done_tick;

  int checks = 0;
  int errors = 0;

  vec_t        exp_q[$];
  logic        smp [0:NSMP-1];
  int unsigned mon_ticks   = 0;
  bit          in_frame    = 1'b0;
  bit          post_done   = 1'b0;
  int unsigned frames_done = 0;
  int unsigned aborts      = 0;

  uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tx_start     (tx_start),
    .s_tick       (s_tick),
    .tx_din       (tx_din),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  // Baud tick: one cycle high every 4 clocks, changed just after the rising edge.
  initial begin
    int unsigned c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      s_tick = (c == 3);
      c = (c + 1) % 4;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic frame_check(input vec_t e);
    logic [DBIT-1:0] got;
    bit start_ok, stop_ok, stable_ok;
    got = '0; start_ok = 1'b1; stop_ok = 1'b1; stable_ok = 1'b1;
    chk("frame_len", 64'(mon_ticks), 64'(FRAME_T));
    for (int k = 0; k < 16; k++) if (smp[k] !== 1'b0) start_ok = 1'b0;
    for (int i = 0; i < int'(DBIT); i++) begin
      got[i] = smp[16 + 16*i + 8];
      for (int k = 0; k < 16; k++) if (smp[16 + 16*i + k] !== got[i]) stable_ok = 1'b0;
    end
    chk("start_bit", 64'(start_ok), 64'd1);
    chk("data_bits", 64'(got), 64'(e.din));
    chk("bit_stable", 64'(stable_ok), 64'd1);
`ifdef UART_TX_PARITY_EN
    chk("parity_bit", 64'(smp[16*(1+DBIT) + 8]), 64'(e.par));
`endif
    for (int k = 0; k < int'(SB_TICK); k++)
      if (smp[16*(1+DBIT+PBITS) + k] !== 1'b1) stop_ok = 1'b0;
    chk("stop_bit", 64'(stop_ok), 64'd1);
  endtask

  // Line monitor: records tx once per s_tick while a frame is in progress.
  always @(negedge clk) begin
    if (post_done) begin
      post_done = 1'b0;
      chk("done_pulse_then_idle", 64'({tx_done_tick, tx_busy}), 64'b00);
    end
    if (!in_frame && tx_busy && !tx_done_tick) begin
      in_frame  = 1'b1;
      mon_ticks = 0;
      for (int k = 0; k < int'(NSMP); k++) smp[k] = 1'bx;
    end
    if (in_frame) begin
      if (tx_done_tick) begin
        in_frame  = 1'b0;
        post_done = 1'b1;
        frames_done++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_frame got=frame exp=none");
        end else begin
          frame_check(exp_q.pop_front());
        end
      end else if (!tx_busy) begin
        in_frame = 1'b0;
        aborts++;
      end else if (s_tick) begin
        if (mon_ticks < NSMP) smp[mon_ticks] = tx;
        mon_ticks++;
      end
    end else if (tx_done_tick) begin
      checks++; errors++;
      $display("FAIL stray_done got=1 exp=0");
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_busy();
    int unsigned n;
    n = 0;
    while (n < 20) begin
      step();
      if (tx_busy) break;
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL wait_busy got=timeout exp=busy");
    end
  endtask

  task automatic wait_frame(input int unsigned target);
    int unsigned n;
    n = 0;
    while (frames_done < target && n < 5000) begin
      step();
      n++;
    end
    if (frames_done < target) begin
      checks++; errors++;
      $display("FAIL wait_frame got=%0d exp=%0d", frames_done, target);
    end
  endtask

  task automatic wait_ticks(input int unsigned t);
    int unsigned n;
    n = 0;
    while (mon_ticks < t && n < 5000) begin
      step();
      n++;
    end
    if (mon_ticks < t) begin
      checks++; errors++;
      $display("FAIL wait_ticks got=%0d exp=%0d", mon_ticks, t);
    end
  endtask

  task automatic send(input logic [DBIT-1:0] d, input logic p, input bit push);
    vec_t e;
    tx_din   = d;
    tx_start = 1'b1;
    wait_busy();
    tx_start = 1'b0;
    e.din = d;
    e.par = p;
    if (push) exp_q.push_back(e);
  endtask

  initial begin
    vec_t            tbl[6];
    vec_t            e;
    logic [DBIT-1:0] b2b[3];
    int unsigned     n0, ab0, gap;
    bit              idle_bad;

    tbl[0] = '{32'hA5A5_0F01, 1'b1};
    tbl[1] = '{32'h0000_0007, 1'b1};
    tbl[2] = '{32'hFFFF_FFFF, 1'b0};
    tbl[3] = '{32'h0000_0000, 1'b0};
    tbl[4] = '{32'h8000_0001, 1'b0};
    tbl[5] = '{32'h1234_5678, 1'b1};
    b2b[0] = 32'h0000_00FF;
    b2b[1] = 32'hC3C3_1111;
    b2b[2] = 32'h7E00_0081;

    reset_n = 1'b0;
    repeat (3) step();
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(tx_busy), 64'd0);
    chk("rst_done", 64'(tx_done_tick), 64'd0);
    reset_n = 1'b1;

    idle_bad = 1'b0;
    repeat (200) begin
      step();
      if (tx !== 1'b1 || tx_busy !== 1'b0) idle_bad = 1'b1;
    end
    chk("idle_line", 64'(idle_bad), 64'd0);
    chk("idle_no_frame", 64'(frames_done), 64'd0);

    for (int i = 0; i < 6; i++) begin
      n0 = frames_done;
      send(tbl[i].din, tbl[i].par, 1'b1);
      wait_frame(n0 + 1);
    end

    // Back-to-back with tx_start held: one busy-low cycle between frames.
    n0 = frames_done;
    tx_din   = b2b[0];
    tx_start = 1'b1;
    wait_busy();
    for (int f = 0; f < 3; f++) begin
      e.din = b2b[f];
      e.par = ^b2b[f];
      exp_q.push_back(e);
      if (f < 2) tx_din = b2b[f+1];
      else       tx_start = 1'b0;
      wait_frame(n0 + f + 1);
      if (f < 2) begin
        gap = 0;
        while (gap < 10) begin
          step();
          if (tx_busy) break;
          gap++;
        end
        chk("b2b_gap", 64'(gap), 64'd1);
      end
    end

    // Request during DATA is ignored.
    n0 = frames_done;
    send(32'h0F0F_3C3C, ^32'h0F0F_3C3C, 1'b1);
    wait_ticks(16 * 6);
    tx_din   = 32'hDEAD_BEEF;
    tx_start = 1'b1;
    repeat (2) step();
    tx_start = 1'b0;
    wait_frame(n0 + 1);
    repeat (300) step();
    chk("no_extra_frame", 64'(frames_done), 64'(n0 + 1));
    chk("idle_after_pulse", 64'(tx_busy), 64'd0);

    // Reset during data bit 10 aborts the frame.
    n0  = frames_done;
    ab0 = aborts;
    send(32'h1357_9BDF, 1'b0, 1'b0);
    wait_ticks(16 * 11 + 5);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_tx", 64'(tx), 64'd1);
    chk("abort_busy", 64'(tx_busy), 64'd0);
    chk("abort_done", 64'(tx_done_tick), 64'd0);
    repeat (3) step();
    reset_n = 1'b1;
    chk("abort_seen", 64'(aborts), 64'(ab0 + 1));
    chk("abort_no_done", 64'(frames_done), 64'(n0));

    n0 = frames_done;
    send(tbl[0].din, tbl[0].par, 1'b1);
    wait_frame(n0 + 1);
    repeat (5) step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DBIT, default 32, number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, stop-bit duration in s_tick pulses (16 = 1 stop bit, 32 = 2).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset; synchronous, active-low.
REQ-005 tx_start  input  1  request to send tx_din; level-sampled each cycle.
REQ-006 s_tick  input  1  one-cycle baud tick at 16x the bit rate, from the external baud generator.
REQ-007 tx_din  input  DBIT  frame payload; sampled only in the accept cycle.
REQ-008 tx  output  1  serial line; idle high; driven directly from a flop.
REQ-009 tx_busy  output  1  high while a frame is in progress.
REQ-010 tx_done_tick  output  1  one-cycle pulse at frame completion.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-012 Accept rule: in IDLE with tx_start=1, the block SHALL latch tx_din into the shift register, clear the tick and bit counters, and enter START on the next edge.
REQ-013 tx_start outside IDLE SHALL be ignored; no queuing of requests.
REQ-014 START SHALL drive tx=0 for exactly 16 s_tick pulses.
REQ-015 DATA SHALL send DBIT bits LSB first, each held for 16 s_tick pulses, shifting right once per bit.
REQ-016 STOP SHALL drive tx=1 for SB_TICK s_tick pulses, then pulse tx_done_tick for one cycle and return to IDLE.
REQ-017 Within a state, the 4-bit tick counter SHALL advance only on cycles with s_tick=1; the state advances on the s_tick that completes the count (counter==15, or SB_TICK-1 in STOP), and the counter then clears to 0.
REQ-018 The bit counter SHALL be $clog2(DBIT) bits wide; DATA exits after bit index DBIT-1.
REQ-019 tx_busy SHALL be high in every state except IDLE; it deasserts in the cycle after tx_done_tick.
REQ-020 tx_start coincident with tx_done_tick SHALL be ignored; it is accepted on the first IDLE cycle if still asserted.
REQ-021 Frame length SHALL be 16*(1+DBIT)+SB_TICK s_tick pulses (544 for the defaults), plus 16 with parity.
REQ-022 Illegal state encodings SHALL recover to IDLE with tx=1.

Reset
REQ-023 With reset_n=0 at a clock edge: state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, all counters and the shift register zero.
REQ-024 Reset mid-frame SHALL abort the frame and drive tx=1 from the next edge; no done pulse is issued.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: after DATA, a PARITY state SHALL send even parity (XOR of all DBIT latched bits) for 16 s_tick pulses, then enter STOP.
REQ-026 Macro undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Structure
REQ-027 Package uart_pkg SHALL hold the state encoding (shared with the receiver), the oversample constant 16, and the default DBIT/SB_TICK values.
REQ-028 No sub-module is required; the baud tick generator (uart_baud_gen) is instantiated outside this block.

Verification
REQ-029 Reset, then idle with s_tick running -> tx=1, tx_busy=0 with no frame.
REQ-030 DBIT=32, tx_din=32'hA5A5_0F01, one start pulse, s_tick every 4 clk -> tx low for 16 ticks, then bits 1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1, then 16 ticks high, tx_done_tick once, 544 ticks total.
REQ-031 tx_start held high continuously -> back-to-back frames with exactly one IDLE cycle between them; each frame shows the tx_din value latched at its own accept.
REQ-032 tx_start pulsed during DATA with a different tx_din -> current frame unchanged and no extra frame.
REQ-033 reset_n=0 during bit 10 of DATA -> tx=1 and tx_busy=0 next edge; no tx_done_tick.
REQ-034 UART_TX_PARITY_EN defined, tx_din=32'h0000_0007 -> parity bit 1 after bit 31, frame 560 ticks.
